// File: rtl/rx_gearbox_12.sv
// rx_gearbox_12: receive-side width adapter. Packs IN_WIDTH-bit lane words
// (bit 0 earliest) into OUT_WIDTH-bit words for the RX FIFO write port,
// with a one-bit slip for block alignment and a sticky overflow flag.
module rx_gearbox_12 #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 12,
    parameter int BUF_W     = 24,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_enable,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 slip,
    input  logic                 idle_wr,
    output logic                 en_wr,
    output logic [OUT_WIDTH-1:0] data_wr,
    output logic [CNT_W-1:0]     fill,
    output logic                 overflow
);

    // Constants sized to the counter so every compare and add is width-matched.
    localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W:0]   IN_W_X  = (CNT_W+1)'(IN_WIDTH);
    localparam logic [CNT_W:0]   BUF_W_X = (CNT_W+1)'(BUF_W);

    logic [BUF_W-1:0]     buf_data_q, buf_data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 en_wr_q, en_wr_d;
    logic [OUT_WIDTH-1:0] data_wr_q, data_wr_d;
    logic                 overflow_q, overflow_d;

    logic [BUF_W-1:0]     rem;
    logic [CNT_W-1:0]     r;
    logic [CNT_W:0]       sum;
    logic [BUF_W-1:0]     keep_mask;
    logic [BUF_W-1:0]     in_shifted;

    // Next-state: emit, then slip the remainder, then append the new word.
    always_comb begin
        buf_data_d = buf_data_q;
        cnt_d      = cnt_q;
        en_wr_d    = 1'b0;
        data_wr_d  = data_wr_q;
        overflow_d = overflow_q;
        rem        = buf_data_q;
        r          = cnt_q;
        sum        = '0;
        keep_mask  = '0;
        in_shifted = '0;

        if (in_enable) begin
            if ((cnt_q >= OUT_W_C) && idle_wr) begin
                en_wr_d   = 1'b1;
                data_wr_d = buf_data_q[OUT_WIDTH-1:0];
                rem       = buf_data_q >> OUT_WIDTH;
                r         = cnt_q - OUT_W_C;
            end

            // Slip acts only on what remains after the emit, never on the emitted word.
            if (slip && (r != '0)) begin
                rem = rem >> 1;
                r   = r - 1'b1;
            end

            sum        = {1'b0, r} + IN_W_X;
            keep_mask  = ~({BUF_W{1'b1}} << r);
            in_shifted = BUF_W'(in_data) << r;

            if (in_valid && (sum <= BUF_W_X)) begin
                buf_data_d = (rem & keep_mask) | in_shifted;
                cnt_d      = sum[CNT_W-1:0];
            end else begin
                // A word that does not fit is dropped whole.
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                buf_data_d = rem & keep_mask;
                cnt_d      = r;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_data_q <= '0;
            cnt_q      <= '0;
            en_wr_q    <= 1'b0;
            data_wr_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
            en_wr_q    <= en_wr_d;
            data_wr_q  <= data_wr_d;
            overflow_q <= overflow_d;
        end
    end

    assign en_wr    = en_wr_q;
    assign data_wr  = data_wr_q;
    assign fill     = cnt_q;
    assign overflow = overflow_q;

endmodule
